// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon decryption control path.
// Holds the round-counter width, permutation round start points and the
// datapath select bundle driven by the controller.
package ascon_pack;

   localparam int ROUND_WIDTH = 4;

   // p12 starts at round 0, p6 at round 6; both finish after round 11
   localparam logic [ROUND_WIDTH-1:0] InitRndP12    = 4'd0;
   localparam logic [ROUND_WIDTH-1:0] InitRndP6     = 4'd6;
   localparam logic [ROUND_WIDTH-1:0] BeforeLastRnd = 4'd10;

   typedef struct packed {
      logic state_init;
      logic xor_init;
      logic sel_ad;
      logic xor_ext;
      logic replace_ct;
      logic xor_dom_sep;
      logic xor_fin;
      logic xor_tag;
   } dp_ctrl_t;

   typedef enum logic [4:0] {
      ST_IDLE, ST_START, ST_DELAY,
      ST_INIT_START, ST_INIT_MID, ST_INIT_END_AD, ST_INIT_END_NOAD,
      ST_AD_PREP, ST_AD_START, ST_AD_MID, ST_AD_END_BLK, ST_AD_END,
      ST_CT_PREP, ST_CT_START, ST_CT_MID, ST_CT_END,
      ST_FIN_PREP, ST_FIN_START, ST_FIN_MID, ST_FIN_END,
      ST_TAG_CHECK, ST_DONE
   } dec_state_e;

endpackage

// File: rtl/ascon_dec_fsm.sv
// Ascon decryption controller: sequences init, AD absorb, CT decrypt, finalization, tag check.
// Ports: start/abort handshake, block counts + delay, FIFO empty/full flags and pop/push strobes,
// round index, state enable, datapath selects, done and registered tag result.
module ascon_dec_fsm
   import ascon_pack::*;
#(
   parameter int DataAddrWidth = 7,
   parameter int DelayWidth    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   input  logic                     abort_i,
   output logic                     ready_o,
   input  logic [DataAddrWidth-1:0] ad_size_i,
   input  logic [DataAddrWidth-1:0] ct_size_i,
   input  logic [DelayWidth-1:0]    delay_i,
   input  logic                     ad_empty_i,
   input  logic                     ct_empty_i,
   output logic                     ad_pop_o,
   output logic                     ct_pop_o,
   input  logic                     pt_full_i,
   output logic                     pt_push_o,
   output logic                     flush_o,
   output logic [ROUND_WIDTH-1:0]   rnd_o,
   output logic                     en_state_o,
   output dp_ctrl_t                 ctrl_o,
   input  logic                     tag_match_i,
   output logic                     done_o,
   output logic                     auth_ok_o
);

   dec_state_e               state_q, state_d;
   logic [DataAddrWidth-1:0] ad_size_q, ad_size_d, ct_size_q, ct_size_d;
   logic [DataAddrWidth-1:0] ad_cnt_q, ad_cnt_d, ct_cnt_q, ct_cnt_d;
   logic [DelayWidth-1:0]    delay_q, delay_d, timer_q, timer_d;
   logic [ROUND_WIDTH-1:0]   rnd_q, rnd_d;
   logic                     auth_ok_q, auth_ok_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ad_size_q <= '0;
         ct_size_q <= '0;
         ad_cnt_q  <= '0;
         ct_cnt_q  <= '0;
         delay_q   <= '0;
         timer_q   <= '0;
         rnd_q     <= '0;
         auth_ok_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ad_size_q <= ad_size_d;
         ct_size_q <= ct_size_d;
         ad_cnt_q  <= ad_cnt_d;
         ct_cnt_q  <= ct_cnt_d;
         delay_q   <= delay_d;
         timer_q   <= timer_d;
         rnd_q     <= rnd_d;
         auth_ok_q <= auth_ok_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ad_size_d  = ad_size_q;
      ct_size_d  = ct_size_q;
      ad_cnt_d   = ad_cnt_q;
      ct_cnt_d   = ct_cnt_q;
      delay_d    = delay_q;
      timer_d    = timer_q;
      rnd_d      = rnd_q;
      auth_ok_d  = auth_ok_q;
      ready_o    = 1'b0;
      flush_o    = 1'b0;
      done_o     = 1'b0;
      ad_pop_o   = 1'b0;
      ct_pop_o   = 1'b0;
      pt_push_o  = 1'b0;
      en_state_o = 1'b0;
      ctrl_o     = '0;

      unique case (state_q)
         ST_IDLE: begin
            ready_o = 1'b1;
            flush_o = 1'b1;
            if (start_i) state_d = ST_START;
         end
         ST_START: begin
            ad_size_d = ad_size_i;
            // a zero CT count would never match the counter; treat as one block
            ct_size_d = (ct_size_i == '0) ? DataAddrWidth'(1) : ct_size_i;
            delay_d   = delay_i;
            ad_cnt_d  = '0;
            ct_cnt_d  = DataAddrWidth'(1);
            timer_d   = '0;
            rnd_d     = InitRndP12;
            state_d   = ST_DELAY;
         end
         ST_DELAY: begin
            if (timer_q == delay_q) state_d = ST_INIT_START;
            else                    timer_d = timer_q + DelayWidth'(1);
         end
         ST_INIT_START: begin
            en_state_o        = 1'b1;
            ctrl_o.state_init = 1'b1;
            rnd_d             = rnd_q + ROUND_WIDTH'(1);
            state_d           = ST_INIT_MID;
         end
         ST_INIT_MID: begin
            en_state_o = 1'b1;
            rnd_d      = rnd_q + ROUND_WIDTH'(1);
            if (rnd_q == BeforeLastRnd)
               state_d = (ad_size_q == '0) ? ST_INIT_END_NOAD : ST_INIT_END_AD;
         end
         ST_INIT_END_AD: begin
            en_state_o      = 1'b1;
            ctrl_o.xor_init = 1'b1;
            state_d         = ST_AD_PREP;
         end
         ST_INIT_END_NOAD: begin
            en_state_o         = 1'b1;
            ctrl_o.xor_init    = 1'b1;
            ctrl_o.xor_dom_sep = 1'b1;
            state_d = (ct_size_q == DataAddrWidth'(1)) ? ST_FIN_PREP : ST_CT_PREP;
         end
         ST_AD_PREP: begin
            if (!ad_empty_i) state_d = ST_AD_START;
         end
         ST_AD_START: begin
            en_state_o     = 1'b1;
            ad_pop_o       = 1'b1;
            ctrl_o.sel_ad  = 1'b1;
            ctrl_o.xor_ext = 1'b1;
            ad_cnt_d       = ad_cnt_q + DataAddrWidth'(1);
            rnd_d          = rnd_q + ROUND_WIDTH'(1);
            state_d        = ST_AD_MID;
         end
         ST_AD_MID: begin
            en_state_o = 1'b1;
            rnd_d      = rnd_q + ROUND_WIDTH'(1);
            if (rnd_q == BeforeLastRnd)
               state_d = (ad_cnt_q == ad_size_q) ? ST_AD_END : ST_AD_END_BLK;
         end
         ST_AD_END_BLK: begin
            en_state_o = 1'b1;
            state_d    = ST_AD_PREP;
         end
         ST_AD_END: begin
            en_state_o         = 1'b1;
            ctrl_o.xor_dom_sep = 1'b1;
            state_d = (ct_size_q == DataAddrWidth'(1)) ? ST_FIN_PREP : ST_CT_PREP;
         end
         ST_CT_PREP: begin
            if (!ct_empty_i && !pt_full_i) state_d = ST_CT_START;
         end
         ST_CT_START: begin
            en_state_o        = 1'b1;
            ct_pop_o          = 1'b1;
            pt_push_o         = 1'b1;
            ctrl_o.replace_ct = 1'b1;
            ct_cnt_d          = ct_cnt_q + DataAddrWidth'(1);
            rnd_d             = rnd_q + ROUND_WIDTH'(1);
            state_d           = ST_CT_MID;
         end
         ST_CT_MID: begin
            en_state_o = 1'b1;
            rnd_d      = rnd_q + ROUND_WIDTH'(1);
            if (rnd_q == BeforeLastRnd) state_d = ST_CT_END;
         end
         ST_CT_END: begin
            en_state_o = 1'b1;
            state_d    = (ct_cnt_q == ct_size_q) ? ST_FIN_PREP : ST_CT_PREP;
         end
         ST_FIN_PREP: begin
            if (!ct_empty_i && !pt_full_i) state_d = ST_FIN_START;
         end
         ST_FIN_START: begin
            en_state_o        = 1'b1;
            ct_pop_o          = 1'b1;
            pt_push_o         = 1'b1;
            ctrl_o.replace_ct = 1'b1;
            ctrl_o.xor_fin    = 1'b1;
            rnd_d             = rnd_q + ROUND_WIDTH'(1);
            state_d           = ST_FIN_MID;
         end
         ST_FIN_MID: begin
            en_state_o = 1'b1;
            rnd_d      = rnd_q + ROUND_WIDTH'(1);
            if (rnd_q == BeforeLastRnd) state_d = ST_FIN_END;
         end
         ST_FIN_END: begin
            en_state_o     = 1'b1;
            ctrl_o.xor_tag = 1'b1;
            state_d        = ST_TAG_CHECK;
         end
         ST_TAG_CHECK: begin
            auth_ok_d = tag_match_i;
            state_d   = ST_DONE;
         end
         ST_DONE: begin
            done_o = 1'b1;
            if (!start_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Load the round start on entry so rnd_o is stable for the whole Prepare wait
      if (state_d == ST_AD_PREP || state_d == ST_CT_PREP) rnd_d = InitRndP6;
      if (state_d == ST_FIN_PREP)                          rnd_d = InitRndP12;

      // Abort wins over everything: drop to Idle and suppress this cycle's strobes
      if (abort_i && state_q != ST_IDLE) begin
         state_d    = ST_IDLE;
         auth_ok_d  = 1'b0;
         ad_pop_o   = 1'b0;
         ct_pop_o   = 1'b0;
         pt_push_o  = 1'b0;
         en_state_o = 1'b0;
         ctrl_o     = '0;
      end
   end

   assign rnd_o     = rnd_q;
   assign auth_ok_o = auth_ok_q;

endmodule

// File: tb/tb_ascon_dec_fsm.sv
module tb_ascon_dec_fsm;
   import ascon_pack::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i, abort_i;
   logic        ready_o;
   logic [6:0]  ad_size_i, ct_size_i;
   logic [15:0] delay_i;
   logic        ad_empty_i, ct_empty_i, ad_pop_o, ct_pop_o;
   logic        pt_full_i, pt_push_o, flush_o;
   logic [ROUND_WIDTH-1:0] rnd_o;
   logic        en_state_o;
   dp_ctrl_t    ctrl_o;
   logic        tag_match_i, done_o, auth_ok_o;

   ascon_dec_fsm #(.DataAddrWidth(7), .DelayWidth(16)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .ready_o(ready_o),
      .ad_size_i(ad_size_i), .ct_size_i(ct_size_i), .delay_i(delay_i),
      .ad_empty_i(ad_empty_i), .ct_empty_i(ct_empty_i), .ad_pop_o(ad_pop_o), .ct_pop_o(ct_pop_o),
      .pt_full_i(pt_full_i), .pt_push_o(pt_push_o), .flush_o(flush_o), .rnd_o(rnd_o),
      .en_state_o(en_state_o), .ctrl_o(ctrl_o), .tag_match_i(tag_match_i),
      .done_o(done_o), .auth_ok_o(auth_ok_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int c_ad, c_ct, c_push, c_en, c_pre, c_dom, c_fin, c_tag, c_init;
   bit en_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      c_ad = 0; c_ct = 0; c_push = 0; c_en = 0; c_pre = 0;
      c_dom = 0; c_fin = 0; c_tag = 0; c_init = 0; en_seen = 0;
   endtask

   // Sample once per cycle on the falling edge and accumulate strobe counts
   task automatic tick();
      @(negedge clk);
      if (ad_pop_o) c_ad++;
      if (ct_pop_o) c_ct++;
      if (pt_push_o) c_push++;
      if (ctrl_o.xor_dom_sep) c_dom++;
      if (ctrl_o.xor_fin) c_fin++;
      if (ctrl_o.xor_tag) c_tag++;
      if (ctrl_o.state_init) c_init++;
      if (en_state_o) begin
         c_en++;
         en_seen = 1;
      end else if (!ready_o && !en_seen && !done_o) c_pre++;
   endtask

   task automatic begin_op(input int ad, input int ct, input int dly, input logic match);
      @(posedge clk); #1;
      ad_size_i = 7'(ad); ct_size_i = 7'(ct); delay_i = 16'(dly);
      tag_match_i = match; start_i = 1'b1;
      clr();
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done_o && n < 500) begin tick(); n++; end
      chk({tag, "_done_reached"}, done_o, 1);
   endtask

   task automatic wait_en(input int target);
      int n = 0;
      while (c_en < target && n < 200) begin tick(); n++; end
      chk("wait_en_reached", c_en, target);
   endtask

   initial begin
      rst_n = 1'b0; start_i = 0; abort_i = 0; ad_size_i = 0; ct_size_i = 0; delay_i = 0;
      ad_empty_i = 0; ct_empty_i = 0; pt_full_i = 0; tag_match_i = 0;
      clr();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ready_o, 1);
      chk("rst_flush", flush_o, 1);
      chk("rst_done", done_o, 0);
      chk("rst_en", en_state_o, 0);
      chk("rst_auth", auth_ok_o, 0);
      chk("rst_rnd", rnd_o, 0);
      rst_n = 1'b1;

      // ---- ad=0, ct=1, delay=0, tag ok ----
      begin_op(0, 1, 0, 1);
      wait_done("s1");
      chk("s1_pre", c_pre, 2);
      chk("s1_en", c_en, 24);
      chk("s1_ctpop", c_ct, 1);
      chk("s1_push", c_push, 1);
      chk("s1_adpop", c_ad, 0);
      chk("s1_domsep", c_dom, 1);
      chk("s1_init", c_init, 1);
      chk("s1_fin", c_fin, 1);
      chk("s1_tag", c_tag, 1);
      chk("s1_auth", auth_ok_o, 1);
      // start held: remain in Done
      repeat (4) tick();
      chk("s1_hold_done", done_o, 1);
      chk("s1_hold_ready", ready_o, 0);
      @(posedge clk); #1 start_i = 0;
      tick();
      tick();
      chk("s1_back_idle", ready_o, 1);
      chk("s1_done_low", done_o, 0);
      clr();
      repeat (4) tick();
      chk("s1_no_restart", c_pre + c_en + c_ct, 0);
      chk("s1_still_ready", ready_o, 1);

      // ---- ad=2, ct=3, delay=3, tag mismatch ----
      begin_op(2, 3, 3, 0);
      wait_done("s2");
      chk("s2_pre", c_pre, 5);
      chk("s2_en", c_en, 48);
      chk("s2_adpop", c_ad, 2);
      chk("s2_ctpop", c_ct, 3);
      chk("s2_push", c_push, 3);
      chk("s2_domsep", c_dom, 1);
      chk("s2_auth", auth_ok_o, 0);
      @(posedge clk); #1 start_i = 0;
      tick(); tick();

      // ---- ct=2 with PT FIFO full stalling CTPrepare ----
      pt_full_i = 1'b1;
      begin_op(0, 2, 0, 1);
      wait_en(12);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("s3_stall_pop", ct_pop_o, 0);
         chk("s3_stall_push", pt_push_o, 0);
         chk("s3_stall_rnd", rnd_o, 6);
         chk("s3_stall_en", en_state_o, 0);
      end
      @(posedge clk); #1 pt_full_i = 1'b0;
      tick();
      chk("s3_rel_nopop", ct_pop_o, 0);
      tick();
      chk("s3_resume_pop", ct_pop_o, 1);
      chk("s3_resume_push", pt_push_o, 1);
      chk("s3_resume_rnd", rnd_o, 6);
      wait_done("s3");
      chk("s3_ctpop", c_ct, 2);
      chk("s3_push", c_push, 2);
      chk("s3_auth", auth_ok_o, 1);
      @(posedge clk); #1 start_i = 0;
      tick(); tick();

      // ---- abort during CTMid ----
      begin_op(0, 2, 0, 1);
      begin
         int n = 0;
         while (c_ct < 1 && n < 200) begin tick(); n++; end
      end
      chk("s4_reached_ct", c_ct, 1);
      @(posedge clk); #1 abort_i = 1'b1;
      @(negedge clk);
      chk("s4_abort_en", en_state_o, 0);
      chk("s4_abort_ctrl", ctrl_o, 0);
      chk("s4_abort_pop", ct_pop_o | pt_push_o | ad_pop_o, 0);
      @(posedge clk); #1 abort_i = 1'b0; start_i = 1'b0;
      @(negedge clk);
      chk("s4_ready", ready_o, 1);
      chk("s4_flush", flush_o, 1);
      chk("s4_auth", auth_ok_o, 0);
      chk("s4_done", done_o, 0);
      clr();
      repeat (4) tick();
      chk("s4_no_strobes", c_ct + c_push + c_ad + c_en, 0);

      // ---- reset during ADMid, then fresh run ----
      begin_op(1, 1, 0, 1);
      begin
         int n = 0;
         while (c_ad < 1 && n < 200) begin tick(); n++; end
      end
      chk("s5_reached_ad", c_ad, 1);
      @(posedge clk); #1 rst_n = 1'b0; start_i = 1'b0;
      #1;
      chk("s5_rst_ready", ready_o, 1);
      chk("s5_rst_flush", flush_o, 1);
      chk("s5_rst_en", en_state_o, 0);
      chk("s5_rst_rnd", rnd_o, 0);
      chk("s5_rst_pop", ad_pop_o | ct_pop_o | pt_push_o, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      begin_op(1, 1, 1, 1);
      wait_done("s5");
      chk("s5_pre", c_pre, 3);
      chk("s5_en", c_en, 30);
      chk("s5_adpop", c_ad, 1);
      chk("s5_ctpop", c_ct, 1);
      chk("s5_push", c_push, 1);
      chk("s5_domsep", c_dom, 1);
      chk("s5_auth", auth_ok_o, 1);
      @(posedge clk); #1 start_i = 0;
      tick(); tick();
      chk("s5_idle", ready_o, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ascon_dec_fsm.md
ASCON_DEC_FSM -- requirements
Module: ascon_dec_fsm

Interface
REQ-001 The block SHALL have parameter DataAddrWidth, default 7, width of block-count inputs and internal block counters.
REQ-002 The block SHALL have parameter DelayWidth, default 16, width of the start-delay value and internal timer.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start_i  in  1  level request to begin one decryption.
REQ-007 abort_i  in  1  cancel current operation.
REQ-008 ready_o  out  1  high only in Idle.
REQ-009 ad_size_i  in  DataAddrWidth  AD block count, 0 = no AD; sampled in Start.
REQ-010 ct_size_i  in  DataAddrWidth  CT block count including final block, >= 1; sampled in Start.
REQ-011 delay_i  in  DelayWidth  pre-init delay in cycles; sampled in Start.
REQ-012 ad_empty_i / ct_empty_i  in  1 each  input FIFO empty flags.
REQ-013 ad_pop_o / ct_pop_o  out  1 each  one-cycle pop strobes.
REQ-014 pt_full_i  in  1  output PT FIFO full.
REQ-015 pt_push_o  out  1  one-cycle PT push strobe.
REQ-016 flush_o  out  1  flush all three FIFOs.
REQ-017 rnd_o  out  ROUND_WIDTH  round index for constant generation.
REQ-018 en_state_o  out  1  permutation state register enable.
REQ-019 ctrl_o  out  dp_ctrl_t  datapath selects: state_init, xor_init, sel_ad, xor_ext, replace_ct, xor_dom_sep, xor_fin, xor_tag.
REQ-020 tag_match_i  in  1  datapath comparator: computed tag equals expected tag.
REQ-021 done_o  out  1  high only in Done.
REQ-022 auth_ok_o  out  1  registered tag-check result; meaningful while done_o.

Function
REQ-023 States SHALL be: Idle, Start, Delay, InitStart, InitMid, InitEndWithAD, InitEndNoAD, ADPrepare, ADStart, ADMid, ADEndBlk, ADEnd, CTPrepare, CTStart, CTMid, CTEnd, FinalPrepare, FinalStart, FinalMid, FinalEnd, TagCheck, Done.
REQ-024 All outputs SHALL default to 0 each cycle except as listed; unused state encodings SHALL go to Idle.
REQ-025 Idle: ready_o=1, flush_o=1; -> Start when start_i.
REQ-026 Start: latch sizes/delay, ad_cnt=0, ct_cnt=1, timer=0, rnd=0 (p12); -> Delay.
REQ-027 Delay: timer increments; -> InitStart when timer==delay_q (delay 0 = one Delay cycle).
REQ-028 Every *Start/*Mid state SHALL assert en_state_o and increment rnd; *Mid -> matching *End state when rnd==10; each End state asserts en_state_o (12 cycles for p12, 6 for p6).
REQ-029 InitStart asserts state_init; InitEnd* assert xor_init; InitEndNoAD chosen when ad_size_q==0, also asserts xor_dom_sep and goes to FinalPrepare if ct_size_q==1, else CTPrepare; InitEndWithAD -> ADPrepare.
REQ-030 ADPrepare: rnd=6; wait while ad_empty_i; ADStart: ad_pop_o, sel_ad, xor_ext, ad_cnt++; after ADMid: ADEnd if ad_cnt==ad_size_q else ADEndBlk -> ADPrepare.
REQ-031 ADEnd asserts xor_dom_sep; -> FinalPrepare if ct_size_q==1 else CTPrepare.
REQ-032 CTPrepare: rnd=6; wait while ct_empty_i or pt_full_i; CTStart: ct_pop_o, pt_push_o, replace_ct, ct_cnt++; CTEnd -> FinalPrepare if ct_cnt==ct_size_q else CTPrepare.
REQ-033 FinalPrepare: rnd=0; same wait as CTPrepare; FinalStart: ct_pop_o, pt_push_o, replace_ct, xor_fin; FinalEnd asserts xor_tag; -> TagCheck.
REQ-034 TagCheck: auth_ok register <= tag_match_i; -> Done.
REQ-035 Done: done_o=1; stay while start_i high; -> Idle when start_i low.
REQ-036 abort_i in any non-Idle state SHALL force Idle next cycle and clear auth_ok, overriding all other transitions and strobes that cycle.
REQ-037 Exactly one pop per consumed block and one push per CT block; no strobes in Prepare states.
REQ-038 Counters SHALL not wrap within a legal operation; ct_size_i==0 is illegal and treated as 1.

Reset
REQ-039 On rst_n low: state Idle, counters/timer 0, auth_ok 0, latched sizes 0; outputs take Idle values (ready_o=1, flush_o=1, rest 0).
REQ-040 Reset mid-operation SHALL discard all progress with no further strobes.

Structure
REQ-041 dp_ctrl_t and constants InitRndP12=0, InitRndP6=6, BeforeLastRnd=10 SHALL live in ascon_pack; ROUND_WIDTH reused from it.
REQ-042 Counters and timer SHALL be inline; no sub-module.

Verification
REQ-043 ad=0, ct=1, delay=0, match=1 -> Start, 1 Delay, 12 init, 12 final, TagCheck, done_o, auth_ok_o=1, 1 ct_pop, 1 pt_push.
REQ-044 ad=2, ct=3, delay=3, match=0 -> 4 Delay cycles, 2 ad_pop, 3 ct_pop, 3 pt_push, xor_dom_sep once, auth_ok_o=0.
REQ-045 ct=2, pt_full_i held 5 cycles in CTPrepare -> no push/pop, rnd_o held 6, resumes one cycle after release.
REQ-046 abort_i in CTMid -> Idle next cycle, ready_o=1, flush_o=1, auth_ok_o=0, no stray strobes.
REQ-047 start_i held high through Done -> stays in Done; drop start_i -> Idle; no restart until start_i reasserted.
REQ-048 rst_n low during ADMid -> immediate Idle outputs; after release, fresh run completes normally.
